// File: rtl/punc_pkg.sv
// PUnC LC3 shared definitions: opcodes, controller states and the
// datapath mux-select encodings used by both controller and datapath.
package punc_pkg;

   typedef enum logic [2:0] {
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_EXEC2,
      ST_HALT
   } state_e;

   localparam logic [3:0] OP_BR   = 4'b0000;
   localparam logic [3:0] OP_ADD  = 4'b0001;
   localparam logic [3:0] OP_LD   = 4'b0010;
   localparam logic [3:0] OP_ST   = 4'b0011;
   localparam logic [3:0] OP_JSR  = 4'b0100;
   localparam logic [3:0] OP_AND  = 4'b0101;
   localparam logic [3:0] OP_LDR  = 4'b0110;
   localparam logic [3:0] OP_STR  = 4'b0111;
   localparam logic [3:0] OP_NOT  = 4'b1001;
   localparam logic [3:0] OP_LDI  = 4'b1010;
   localparam logic [3:0] OP_STI  = 4'b1011;
   localparam logic [3:0] OP_JMP  = 4'b1100;
   localparam logic [3:0] OP_LEA  = 4'b1110;
   localparam logic [3:0] OP_HALT = 4'b1111;

   localparam logic [1:0] PC_SEL_PC_8_0  = 2'd0;
   localparam logic [1:0] PC_SEL_PC_10_0 = 2'd1;
   localparam logic [1:0] PC_SEL_RF_RQ   = 2'd2;

   localparam logic [1:0] DM_R_PC        = 2'd0;
   localparam logic [1:0] DM_R_PC_8_0    = 2'd1;
   localparam logic [1:0] DM_R_RF_RP     = 2'd2;
   localparam logic [1:0] DM_R_RF_RQ_5_0 = 2'd3;

   localparam logic [1:0] DM_W_PC_8_0    = 2'd0;
   localparam logic [1:0] DM_W_TEMP      = 2'd1;
   localparam logic [1:0] DM_W_RF_RQ_5_0 = 2'd2;

   localparam logic [1:0] RF_WD_ALU    = 2'd0;
   localparam logic [1:0] RF_WD_PC_8_0 = 2'd1;
   localparam logic [1:0] RF_WD_DMEM_R = 2'd2;
   localparam logic [1:0] RF_WD_PC     = 2'd3;

   localparam logic RF_WA_11_9 = 1'b0;
   localparam logic RF_WA_R7   = 1'b1;

   localparam logic RF_RP_11_9 = 1'b0;
   localparam logic RF_RP_2_0  = 1'b1;

   localparam logic ALU_A_RP   = 1'b0;
   localparam logic ALU_A_IMM  = 1'b1;

   localparam logic [1:0] ALU_PASS_A = 2'd0;
   localparam logic [1:0] ALU_ADD    = 2'd1;
   localparam logic [1:0] ALU_AND    = 2'd2;
   localparam logic [1:0] ALU_NOT_B  = 2'd3;

   function automatic logic two_step(input logic [3:0] op);
      return (op == OP_LDI) || (op == OP_STI);
   endfunction

endpackage

// File: rtl/punc_control.sv
// PUnC LC3 controller: FETCH/DECODE/EXEC[/EXEC2] sequencer driving all
// datapath strobes and selects, plus halt status and retire counter.
module punc_control
   import punc_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [15:0]      ir,
   input  logic             nzp_match,
   output logic             pc_ld,
   output logic             pc_clr,
   output logic             pc_inc,
   output logic [1:0]       pc_sel,
   output logic             ir_ld,
   output logic             ir_clr,
   output logic             dmem_rd,
   output logic             dmem_wr,
   output logic [1:0]       dmem_r_addr_sel,
   output logic [1:0]       dmem_w_addr_sel,
   output logic [1:0]       rf_w_data_sel,
   output logic             rf_w_addr_sel,
   output logic             rf_w_wr,
   output logic             rf_rp_addr_sel,
   output logic             rf_rp_rd,
   output logic             rf_rq_rd,
   output logic             temp_ld,
   output logic             nzp_ld,
   output logic             nzp_clr,
   output logic [1:0]       alu_sel,
   output logic             alu_in_a_sel,
   output logic             halted,
   output logic [CNT_W-1:0] instr_count
);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             retire;
   logic [3:0]       op;
   logic             unused_ir;

   assign op          = ir[15:12];
   assign unused_ir   = ^{ir[10:6], ir[4:0]};
   assign instr_count = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      retire  = 1'b0;
      unique case (state_q)
         ST_FETCH:  state_d = ST_DECODE;
         ST_DECODE: state_d = (op == OP_HALT) ? ST_HALT : ST_EXEC;
         ST_EXEC: begin
            if (two_step(op)) begin
               state_d = ST_EXEC2;
            end else begin
               state_d = ST_FETCH;
               retire  = 1'b1;
            end
         end
         ST_EXEC2: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
         end
         ST_HALT:   state_d = ST_HALT;
         default:   state_d = ST_FETCH;
      endcase
      cnt_d = cnt_q;
      if (retire && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
   end

   always_comb begin
      pc_ld           = 1'b0;
      pc_clr          = 1'b0;
      pc_inc          = 1'b0;
      pc_sel          = PC_SEL_PC_8_0;
      ir_ld           = 1'b0;
      ir_clr          = 1'b0;
      dmem_rd         = 1'b0;
      dmem_wr         = 1'b0;
      dmem_r_addr_sel = DM_R_PC;
      dmem_w_addr_sel = DM_W_PC_8_0;
      rf_w_data_sel   = RF_WD_ALU;
      rf_w_addr_sel   = RF_WA_11_9;
      rf_w_wr         = 1'b0;
      rf_rp_addr_sel  = RF_RP_11_9;
      rf_rp_rd        = 1'b0;
      rf_rq_rd        = 1'b0;
      temp_ld         = 1'b0;
      nzp_ld          = 1'b0;
      nzp_clr         = 1'b0;
      alu_sel         = ALU_PASS_A;
      alu_in_a_sel    = ALU_A_RP;
      halted          = 1'b0;
      // Reset overrides everything so an in-flight store is dropped
      if (rst) begin
         pc_clr  = 1'b1;
         ir_clr  = 1'b1;
         nzp_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_FETCH: begin
               dmem_rd         = 1'b1;
               dmem_r_addr_sel = DM_R_PC;
               ir_ld           = 1'b1;
               pc_inc          = 1'b1;
            end
            ST_EXEC: begin
               case (op)
                  OP_ADD, OP_AND, OP_NOT: begin
                     if (op != OP_NOT) begin
                        rf_rp_addr_sel = RF_RP_2_0;
                        rf_rp_rd       = 1'b1;
                        alu_in_a_sel   = ir[5] ? ALU_A_IMM : ALU_A_RP;
                        alu_sel        = (op == OP_ADD) ? ALU_ADD : ALU_AND;
                     end else begin
                        alu_sel = ALU_NOT_B;
                     end
                     rf_rq_rd      = 1'b1;
                     rf_w_data_sel = RF_WD_ALU;
                     rf_w_wr       = 1'b1;
                     nzp_ld        = 1'b1;
                  end
                  OP_BR: begin
                     pc_ld  = nzp_match;
                     pc_sel = PC_SEL_PC_8_0;
                  end
                  OP_JMP: begin
                     rf_rq_rd = 1'b1;
                     pc_ld    = 1'b1;
                     pc_sel   = PC_SEL_RF_RQ;
                  end
                  OP_JSR: begin
                     rf_w_addr_sel = RF_WA_R7;
                     rf_w_data_sel = RF_WD_PC;
                     rf_w_wr       = 1'b1;
                     pc_ld         = 1'b1;
                     pc_sel        = ir[11] ? PC_SEL_PC_10_0 : PC_SEL_RF_RQ;
                     rf_rq_rd      = ~ir[11];
                  end
                  OP_LD, OP_LDR, OP_LDI: begin
                     dmem_rd         = 1'b1;
                     dmem_r_addr_sel = DM_R_PC_8_0;
                     if (op == OP_LDR) begin
                        dmem_r_addr_sel = DM_R_RF_RQ_5_0;
                        rf_rq_rd        = 1'b1;
                     end
                     rf_w_data_sel = RF_WD_DMEM_R;
                     rf_w_wr       = 1'b1;
                     nzp_ld        = (op != OP_LDI);
                  end
                  OP_LEA: begin
                     rf_w_data_sel = RF_WD_PC_8_0;
                     rf_w_wr       = 1'b1;
                     nzp_ld        = 1'b1;
                  end
                  OP_ST, OP_STR: begin
                     rf_rp_rd        = 1'b1;
                     dmem_wr         = 1'b1;
                     dmem_w_addr_sel = DM_W_PC_8_0;
                     if (op == OP_STR) begin
                        dmem_w_addr_sel = DM_W_RF_RQ_5_0;
                        rf_rq_rd        = 1'b1;
                     end
                  end
                  OP_STI: begin
                     dmem_rd         = 1'b1;
                     dmem_r_addr_sel = DM_R_PC_8_0;
                     temp_ld         = 1'b1;
                  end
                  default: ;
               endcase
            end
            ST_EXEC2: begin
               rf_rp_addr_sel = RF_RP_11_9;
               rf_rp_rd       = 1'b1;
               if (op == OP_LDI) begin
                  dmem_rd         = 1'b1;
                  dmem_r_addr_sel = DM_R_RF_RP;
                  rf_w_data_sel   = RF_WD_DMEM_R;
                  rf_w_wr         = 1'b1;
                  nzp_ld          = 1'b1;
               end else begin
                  dmem_wr         = 1'b1;
                  dmem_w_addr_sel = DM_W_TEMP;
               end
            end
            ST_HALT: halted = 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_punc_control.sv
// Directed bench for punc_control: per-opcode vector table plus
// reset, HALT, aborted-STI and counter saturation sequences.
module tb_punc_control;

   localparam int CW = 4;

   typedef struct packed {
      logic       pc_ld;
      logic       pc_clr;
      logic       pc_inc;
      logic [1:0] pc_sel;
      logic       ir_ld;
      logic       ir_clr;
      logic       dmem_rd;
      logic       dmem_wr;
      logic [1:0] r_addr;
      logic [1:0] w_addr;
      logic [1:0] w_data;
      logic       w_dst;
      logic       w_wr;
      logic       rp_sel;
      logic       rp_rd;
      logic       rq_rd;
      logic       temp_ld;
      logic       nzp_ld;
      logic       nzp_clr;
      logic [1:0] alu_sel;
      logic       a_sel;
      logic       halted;
   } ctl_t;

   typedef struct {
      string       name;
      logic [15:0] ir;
      logic        nzp;
      logic        two;
      ctl_t        e1;
      ctl_t        e2;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   ir;
   logic          nzp_match;
   logic          pc_ld, pc_clr, pc_inc, ir_ld, ir_clr;
   logic          dmem_rd, dmem_wr, rf_w_addr_sel, rf_w_wr;
   logic          rf_rp_addr_sel, rf_rp_rd, rf_rq_rd;
   logic          temp_ld, nzp_ld, nzp_clr, alu_in_a_sel, halted;
   logic [1:0]    pc_sel, dmem_r_addr_sel, dmem_w_addr_sel;
   logic [1:0]    rf_w_data_sel, alu_sel;
   logic [CW-1:0] instr_count;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   punc_control #(.CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .ir(ir), .nzp_match(nzp_match),
      .pc_ld(pc_ld), .pc_clr(pc_clr), .pc_inc(pc_inc),
      .pc_sel(pc_sel), .ir_ld(ir_ld), .ir_clr(ir_clr),
      .dmem_rd(dmem_rd), .dmem_wr(dmem_wr),
      .dmem_r_addr_sel(dmem_r_addr_sel),
      .dmem_w_addr_sel(dmem_w_addr_sel),
      .rf_w_data_sel(rf_w_data_sel),
      .rf_w_addr_sel(rf_w_addr_sel), .rf_w_wr(rf_w_wr),
      .rf_rp_addr_sel(rf_rp_addr_sel), .rf_rp_rd(rf_rp_rd),
      .rf_rq_rd(rf_rq_rd), .temp_ld(temp_ld), .nzp_ld(nzp_ld),
      .nzp_clr(nzp_clr), .alu_sel(alu_sel),
      .alu_in_a_sel(alu_in_a_sel), .halted(halted),
      .instr_count(instr_count)
   );

   ctl_t got;
   assign got = {pc_ld, pc_clr, pc_inc, pc_sel, ir_ld, ir_clr,
                 dmem_rd, dmem_wr, dmem_r_addr_sel, dmem_w_addr_sel,
                 rf_w_data_sel, rf_w_addr_sel, rf_w_wr,
                 rf_rp_addr_sel, rf_rp_rd, rf_rq_rd, temp_ld,
                 nzp_ld, nzp_clr, alu_sel, alu_in_a_sel, halted};

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input ctl_t exp);
      total++;
      if (got === exp && !(pc_inc && pc_ld)) passed++;
      else $display("FAIL %s: ctl got %h want %h", name, got, exp);
   endtask

   task automatic chk_cnt(input string name, input int exp);
      total++;
      if (instr_count === CW'(exp)) passed++;
      else $display("FAIL %s: instr_count got %0d want %0d",
                    name, instr_count, exp);
   endtask

   ctl_t e_rst, e_fetch, e_idle, e_halt;
   vec_t vecs[$];

   task automatic add(input vec_t v);
      vecs.push_back(v);
   endtask

   initial begin
      vec_t v;
      int   n;

      e_rst   = '0;
      e_rst.pc_clr = 1; e_rst.ir_clr = 1; e_rst.nzp_clr = 1;
      e_fetch = '0;
      e_fetch.dmem_rd = 1; e_fetch.ir_ld = 1; e_fetch.pc_inc = 1;
      e_idle  = '0;
      e_halt  = '0;
      e_halt.halted = 1;

      v = '{name:"", ir:16'h0, nzp:1'b0, two:1'b0, e1:'0, e2:'0};

      v.name = "ADDi"; v.ir = 16'h1262; v.e1 = '0;
      v.e1.rp_sel = 1; v.e1.rp_rd = 1; v.e1.rq_rd = 1;
      v.e1.a_sel = 1; v.e1.alu_sel = 1;
      v.e1.w_wr = 1; v.e1.nzp_ld = 1; add(v);

      v.name = "ANDr"; v.ir = 16'h5042; v.e1 = '0;
      v.e1.rp_sel = 1; v.e1.rp_rd = 1; v.e1.rq_rd = 1;
      v.e1.alu_sel = 2; v.e1.w_wr = 1; v.e1.nzp_ld = 1; add(v);

      v.name = "NOT"; v.ir = 16'h927F; v.e1 = '0;
      v.e1.rq_rd = 1; v.e1.alu_sel = 3;
      v.e1.w_wr = 1; v.e1.nzp_ld = 1; add(v);

      v.name = "BRz_nt"; v.ir = 16'h0403; v.e1 = '0; add(v);

      v.name = "BRz_t"; v.nzp = 1; v.e1 = '0; v.e1.pc_ld = 1; add(v);
      v.nzp = 0;

      v.name = "JMP"; v.ir = 16'hC1C0; v.e1 = '0;
      v.e1.rq_rd = 1; v.e1.pc_ld = 1; v.e1.pc_sel = 2; add(v);

      v.name = "JSR"; v.ir = 16'h4802; v.e1 = '0;
      v.e1.w_dst = 1; v.e1.w_data = 3; v.e1.w_wr = 1;
      v.e1.pc_ld = 1; v.e1.pc_sel = 1; add(v);

      v.name = "JSRR"; v.ir = 16'h41C0;
      v.e1.pc_sel = 2; v.e1.rq_rd = 1; add(v);

      v.name = "LD"; v.ir = 16'h2205; v.e1 = '0;
      v.e1.dmem_rd = 1; v.e1.r_addr = 1; v.e1.w_data = 2;
      v.e1.w_wr = 1; v.e1.nzp_ld = 1; add(v);

      v.name = "LDR"; v.ir = 16'h6245;
      v.e1.r_addr = 3; v.e1.rq_rd = 1; add(v);

      v.name = "LEA"; v.ir = 16'hE205; v.e1 = '0;
      v.e1.w_data = 1; v.e1.w_wr = 1; v.e1.nzp_ld = 1; add(v);

      v.name = "ST"; v.ir = 16'h3205; v.e1 = '0;
      v.e1.rp_rd = 1; v.e1.dmem_wr = 1; add(v);

      v.name = "STR"; v.ir = 16'h7245;
      v.e1.rq_rd = 1; v.e1.w_addr = 2; add(v);

      v.name = "LDI"; v.ir = 16'hA205; v.two = 1; v.e1 = '0;
      v.e1.dmem_rd = 1; v.e1.r_addr = 1; v.e1.w_data = 2;
      v.e1.w_wr = 1;
      v.e2 = '0;
      v.e2.rp_rd = 1; v.e2.dmem_rd = 1; v.e2.r_addr = 2;
      v.e2.w_data = 2; v.e2.w_wr = 1; v.e2.nzp_ld = 1; add(v);

      v.name = "STI"; v.ir = 16'hB205; v.e1 = '0;
      v.e1.dmem_rd = 1; v.e1.r_addr = 1; v.e1.temp_ld = 1;
      v.e2 = '0;
      v.e2.rp_rd = 1; v.e2.dmem_wr = 1; v.e2.w_addr = 1; add(v);
      v.two = 0;

      v.name = "NOP8"; v.ir = 16'h8000; v.e1 = '0; add(v);
      v.name = "NOPD"; v.ir = 16'hD000; add(v);

      rst = 1; ir = 16'h0; nzp_match = 0;
      tick(); chk("rst_c1", e_rst);
      tick(); chk("rst_c2", e_rst);
      rst = 0; #1;
      chk_cnt("cnt_after_rst", 0);

      n = 0;
      foreach (vecs[i]) begin
         ir = vecs[i].ir; nzp_match = vecs[i].nzp; #1;
         chk({vecs[i].name, "_fetch"}, e_fetch);
         tick(); chk({vecs[i].name, "_decode"}, e_idle);
         tick(); chk({vecs[i].name, "_exec"}, vecs[i].e1);
         if (vecs[i].two) begin
            tick(); chk({vecs[i].name, "_exec2"}, vecs[i].e2);
         end
         tick();
         n++;
         chk_cnt({vecs[i].name, "_cnt"}, (n > 15) ? 15 : n);
      end

      ir = 16'hF025; nzp_match = 0; #1;
      chk("halt_fetch", e_fetch);
      tick(); chk("halt_decode", e_idle);
      for (int k = 0; k < 20; k++) begin
         tick(); chk("halt_hold", e_halt);
      end
      chk_cnt("halt_cnt_sat", 15);

      rst = 1; #1; chk("rst_in_halt", e_rst);
      tick(); rst = 0; #1;
      chk("after_halt_fetch", e_fetch);
      chk_cnt("after_halt_cnt", 0);

      ir = 16'hB205;
      tick(); chk("sti_decode", e_idle);
      tick(); chk("sti_exec", vecs[14].e1);
      tick();
      rst = 1; #1; chk("sti_abort", e_rst);
      tick(); rst = 0; #1;
      chk("sti_abort_fetch", e_fetch);
      chk_cnt("sti_abort_cnt", 0);

      ir = 16'h1262;
      tick(); tick(); tick();
      chk("resume_fetch", e_fetch);
      chk_cnt("resume_cnt", 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/punc_control.md
Name: punc_control

Overview:
- FSM controller that sequences the PUnC LC3 datapath.
- Fetches, decodes and executes one LC3 instruction at a time by driving every datapath strobe and mux select.
- Sits beside the datapath in the PUnC top level. Consumes `ir_out` and `nzp_match`; produces all control inputs.
- Also exports halt status and a retired-instruction counter for the debug bench.

Parameters:
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  synchronous, active-high reset
ir  input  16  datapath ir_out
nzp_match  input  1  datapath branch-condition match
pc_ld, pc_clr, pc_inc  output  1 each  PC strobes
pc_sel  output  2  PC write-data select
ir_ld, ir_clr  output  1 each  IR strobes
dmem_rd, dmem_wr  output  1 each  memory strobes
dmem_r_addr_sel, dmem_w_addr_sel  output  2 each  memory address selects
rf_w_data_sel  output  2  RF write-data select
rf_w_addr_sel, rf_w_wr  output  1 each  RF write address select, write enable
rf_rp_addr_sel, rf_rp_rd, rf_rq_rd  output  1 each  RF read controls
temp_ld, nzp_ld, nzp_clr  output  1 each  temp and NZP strobes
alu_sel  output  2  ALU function
alu_in_a_sel  output  1  ALU A operand select
halted  output  1  high while in HALT
instr_count  output  CNT_W  instructions retired since reset

Behaviour:

States: FETCH, DECODE, EXEC, EXEC2, HALT. State register only; all control outputs are Moore/Mealy combinational from state, ir and nzp_match.

Default each cycle:
- All strobes 0.
- All selects 0.

Reset:
- While rst=1, outputs are forced to pc_clr=ir_clr=nzp_clr=1, all other strobes 0, so the datapath clears on the same edge.
- On that edge: state<=FETCH, instr_count<=0.
- Reset asserted in any state, including mid-LDI/STI at EXEC2 or in HALT, aborts the instruction without a memory write.

FETCH:
- Drive dmem_rd=1, dmem_r_addr_sel=PC, ir_ld=1, pc_inc=1.
- Next state DECODE.

DECODE:
- No strobes.
- Next state: HALT if ir[15:12]=1111, else EXEC.

EXEC, by opcode ir[15:12]:
- ADD 0001 / AND 0101:
  - rf_rp_addr_sel=2_0, rp_rd=1, rq_rd=1.
  - alu_in_a_sel = imm4_0 if ir[5] else Rp.
  - alu_sel = ADD / AND.
  - rf_w_data_sel=ALU, rf_w_addr_sel=11_9, rf_w_wr=1, nzp_ld=1.
- NOT 1001: rq_rd=1, alu_sel=NOT_B, then the same write/nzp controls as ADD.
- BR 0000: if nzp_match then pc_ld=1, pc_sel=PC_8_0. An ir[11:9]=000 encoding branches unconditionally (datapath match rule).
- JMP 1100: rq_rd=1, pc_ld=1, pc_sel=RF_Rq.
- JSR/JSRR 0100:
  - rf_w_addr_sel=R7, rf_w_data_sel=PC, rf_w_wr=1, pc_ld=1.
  - pc_sel = PC_10_0 if ir[11] else RF_Rq (rq_rd=1).
  - Same-cycle R7 write plus JSRR R7 reads the old R7 (write lands at the edge).
- LD 0010: dmem_rd=1, dmem_r_addr_sel=PC_8_0, rf_w_data_sel=DMem_R, rf_w_addr_sel=11_9, rf_w_wr=1, nzp_ld=1.
- LDR 0110: as LD but dmem_r_addr_sel=RF_Rq_5_0, rq_rd=1.
- LEA 1110: rf_w_data_sel=PC_8_0, rf_w_addr_sel=11_9, rf_w_wr=1, nzp_ld=1.
- ST 0011: rf_rp_addr_sel=11_9, rp_rd=1, dmem_wr=1, dmem_w_addr_sel=PC_8_0.
- STR 0111: as ST with dmem_w_addr_sel=RF_Rq_5_0, rq_rd=1.
- LDI 1010: EXEC is identical to LD but with nzp_ld=0 (pointer written into DR).
- STI 1011: EXEC drives dmem_rd=1, dmem_r_addr_sel=PC_8_0, temp_ld=1.
- Opcodes 1000/1101: no-op.

Next state from EXEC: EXEC2 for LDI/STI, else FETCH.

EXEC2:
- LDI:
  - rf_rp_addr_sel=11_9, rp_rd=1.
  - dmem_rd=1, dmem_r_addr_sel=RF_Rp.
  - rf_w_data_sel=DMem_R, rf_w_addr_sel=11_9, rf_w_wr=1, nzp_ld=1.
- STI: rf_rp_addr_sel=11_9, rp_rd=1, dmem_wr=1, dmem_w_addr_sel=Temp.
- Next state FETCH.

HALT:
- halted=1, no strobes.
- Stays until rst.

Invariants:
- pc_inc and pc_ld are never asserted together.
- dmem_wr only occurs in EXEC (ST/STR) or EXEC2 (STI).

instr_count:
- Increments on the last execute cycle of each instruction (EXEC→FETCH or EXEC2→FETCH), including no-ops.
- HALT does not count.
- Saturates at all-ones.

Latency: 3 cycles per instruction; 4 cycles for LDI/STI.

Decomposition:
Shared package punc_pkg holds:
- Opcode constants.
- State enum.
- Select encodings (single source for datapath and controller):
  - pc_sel: PC_8_0=0, PC_10_0=1, RF_Rq=2.
  - dmem_r_addr_sel: PC=0, PC_8_0=1, RF_Rp=2, RF_Rq_5_0=3.
  - dmem_w_addr_sel: PC_8_0=0, Temp=1, RF_Rq_5_0=2.
  - rf_w_data_sel: ALU=0, PC_8_0=1, DMem_R=2, PC=3.
  - rf_w_addr_sel: 11_9=0, R7=1.
  - rf_rp_addr_sel: 11_9=0, 2_0=1.
  - alu_in_a_sel: Rp=0, imm4_0=1.
  - alu_sel: PassA=0, ADD=1, AND=2, NOT_B=3.

No sub-module is needed. Next-state logic and output decode are separate always blocks within punc_control.

Test Plan:
1. Reset held 2 cycles → pc_clr/ir_clr/nzp_clr=1 and all other strobes 0; after release, FETCH outputs ir_ld=1, pc_inc=1, dmem_r_addr_sel=0, with instr_count=0.
2. ir=16'h1262 (ADD R1,R1,#2) through FETCH/DECODE/EXEC → EXEC shows alu_in_a_sel=1, alu_sel=1, rf_w_wr=1, nzp_ld=1; back in FETCH on the 4th cycle; instr_count=1.
3. ir=16'h0403 (BRz) with nzp_match=0 → no pc_ld; repeated with nzp_match=1 → pc_ld=1, pc_sel=0 in EXEC.
4. ir=16'hA205 (LDI R1) → EXEC: dmem_r_addr_sel=1, rf_w_wr=1, nzp_ld=0; EXEC2: dmem_r_addr_sel=2, rp_addr_sel=0, nzp_ld=1; 4-cycle instruction. ir=16'hB205 (STI) → temp_ld then dmem_wr with w_addr_sel=1.
5. ir=16'h4802 (JSR) → rf_w_addr_sel=1, rf_w_data_sel=3, pc_sel=1, pc_ld=1, pc_inc=0; ir=16'h41C0 (JSRR R7) → pc_sel=2.
6. ir=16'hF025 → HALT reached after DECODE, halted=1, no strobes for 20 cycles; rst mid-STI EXEC2 → dmem_wr=0 that cycle, state FETCH next.
